// File: rtl/i2c_eeprom_slave.sv
// I2C slave emulating a 256-byte 24Cxx-style serial EEPROM.
// SCL/SDA are oversampled with clk_i; the slave only ever pulls sda low or releases it.
module i2c_eeprom_slave #(
    parameter logic [6:0] ADDRESS   = 7'b1010_000,
    parameter int         MEM_DEPTH = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    inout  wire  scl_io,
    inout  wire  sda_io
);

    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        ACK_DEV,
        WORD_ADDR,
        ACK_WA,
        WR_DATA,
        ACK_WR,
        RD_DATA,
        RD_MACK,
        WAIT_STOP
    } state_e;

    logic scl_s1_q, scl_s2_q, scl_h_q;
    logic sda_s1_q, sda_s2_q, sda_h_q;

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          sda_oe_q, sda_oe_d;

    logic [7:0]    mem_q [MEM_DEPTH];
    logic          mem_we;
    logic [7:0]    mem_wdata;

    logic          scl_rise, scl_fall;
    logic          start_det, stop_det;
    logic [7:0]    byte_in;
    logic [7:0]    rd_byte;
    logic [AW-1:0] ptr_inc;

    assign sda_io = sda_oe_q ? 1'b0 : 1'bz;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_h_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_h_q  <= 1'b1;
        end else begin
            scl_s1_q <= scl_io;
            scl_s2_q <= scl_s1_q;
            scl_h_q  <= scl_s2_q;
            sda_s1_q <= sda_io;
            sda_s2_q <= sda_s1_q;
            sda_h_q  <= sda_s2_q;
        end
    end

    assign scl_rise  = scl_s2_q & ~scl_h_q;
    assign scl_fall  = ~scl_s2_q & scl_h_q;
    assign start_det = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;

    assign byte_in = {shift_q[6:0], sda_s2_q};
    assign rd_byte = mem_q[ptr_q];
    assign ptr_inc = (ptr_q == AW'(MEM_DEPTH - 1)) ? '0 : ptr_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            ptr_q    <= '0;
            sda_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            ptr_q    <= ptr_d;
            sda_oe_q <= sda_oe_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= 8'hFF;
            end
        end else if (mem_we) begin
            mem_q[ptr_q] <= mem_wdata;
        end
    end

    // Ack states see two SCL falls: the first starts the ack, the second ends it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        mem_we    = 1'b0;
        mem_wdata = byte_in;

        if (start_det) begin
            state_d  = DEV_ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, WAIT_STOP: begin
                end
                DEV_ADDR: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (byte_in[7:1] == ADDRESS) begin
                                state_d = ACK_DEV;
                            end else begin
                                state_d = WAIT_STOP;
                            end
                        end
                    end
                end
                ACK_DEV: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else if (shift_q[0]) begin
                            shift_d  = rd_byte;
                            sda_oe_d = ~rd_byte[7];
                            cnt_d    = '0;
                            state_d  = RD_DATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = WORD_ADDR;
                        end
                    end
                end
                WORD_ADDR: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            ptr_d   = byte_in[AW-1:0];
                            state_d = ACK_WA;
                        end
                    end
                end
                ACK_WA, ACK_WR: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            mem_we  = 1'b1;
                            ptr_d   = ptr_inc;
                            state_d = ACK_WR;
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            ptr_d   = ptr_inc;
                            state_d = RD_MACK;
                        end
                    end else if (scl_fall) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                RD_MACK: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            shift_d  = rd_byte;
                            sda_oe_d = ~rd_byte[7];
                            cnt_d    = '0;
                            state_d  = RD_DATA;
                        end
                    end else if (scl_rise) begin
                        if (sda_s2_q) begin
                            state_d = WAIT_STOP;
                        end else begin
                            cnt_d = 3'd1;
                        end
                    end
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Scoreboard bench for i2c_eeprom_slave: bit-banged I2C master,
// expected values queued at stimulus time, compared by a separate monitor.
`timescale 1ns/1ps
module tb_i2c_eeprom_slave;

    localparam int Q = 80;

    logic clk = 1'b0;
    logic rst_n;
    logic scl_m;
    logic sda_low;
    wire  scl_w;
    wire  sda_w;

    always #5 clk = ~clk;

    pullup (scl_w);
    pullup (sda_w);
    assign scl_w = scl_m ? 1'bz : 1'b0;
    assign sda_w = sda_low ? 1'b0 : 1'bz;

    i2c_eeprom_slave dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .scl_io (scl_w),
        .sda_io (sda_w)
    );

    string      exp_name [$];
    logic [7:0] exp_val  [$];
    logic [7:0] obs_val  [$];
    int checks = 0;
    int passes = 0;

    initial begin
        logic [7:0] a, e;
        string      n;
        forever begin
            @(negedge clk);
            while (obs_val.size() != 0) begin
                a = obs_val.pop_front();
                checks++;
                if (exp_val.size() == 0) begin
                    $display("FAIL unexpected_obs: got %h, none expected", a);
                end else begin
                    e = exp_val.pop_front();
                    n = exp_name.pop_front();
                    if (a === e) passes++;
                    else $display("FAIL %s: got %h expected %h", n, a, e);
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic push_exp(input string nm, input logic [7:0] v);
        exp_name.push_back(nm);
        exp_val.push_back(v);
    endtask

    task automatic bit_cycle(input logic b, output logic r);
        sda_low = ~b;
        #Q; scl_m = 1'b1;
        #Q; r = sda_w;
        #Q; scl_m = 1'b0;
        #Q;
    endtask

    task automatic start_c();
        sda_low = 1'b0;
        #Q; scl_m = 1'b1;
        #Q; sda_low = 1'b1;
        #Q; scl_m = 1'b0;
        #Q;
    endtask

    task automatic stop_c();
        sda_low = 1'b1;
        #Q; scl_m = 1'b1;
        #Q; sda_low = 1'b0;
        #Q;
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic ack,
                           input string nm);
        logic r;
        push_exp(nm, {7'd0, ~ack});
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], r);
        bit_cycle(1'b1, r);
        obs_val.push_back({7'd0, r});
    endtask

    task automatic rd_byte(input logic [7:0] e, input logic mack,
                           input string nm);
        logic [7:0] d;
        logic       r;
        d = '0;
        push_exp(nm, e);
        for (int i = 0; i < 8; i++) begin
            bit_cycle(1'b1, r);
            d = {d[6:0], r};
        end
        bit_cycle(~mack, r);
        obs_val.push_back(d);
    endtask

    task automatic rand_read_setup(input logic [7:0] wa, input string nm);
        start_c();
        wr_byte(8'hA0, 1'b1, {nm, "_dev_w"});
        wr_byte(wa, 1'b1, {nm, "_wa"});
        start_c();
        wr_byte(8'hA1, 1'b1, {nm, "_dev_r"});
    endtask

    initial begin
        logic r;
        rst_n   = 1'b0;
        scl_m   = 1'b1;
        sda_low = 1'b0;
        repeat (5) @(posedge clk);
        push_exp("reset_sda", 8'h01);
        obs_val.push_back({7'd0, sda_w});
        #3 rst_n = 1'b1;
        #Q;

        // current-address reads after reset
        start_c();
        wr_byte(8'hA1, 1'b1, "t3_dev0");
        rd_byte(8'hFF, 1'b0, "t3_addr0");
        stop_c();
        start_c();
        wr_byte(8'hA1, 1'b1, "t3_dev1");
        rd_byte(8'hFF, 1'b0, "t3_addr1");
        stop_c();

        // sequential write, random sequential read
        start_c();
        wr_byte(8'hA0, 1'b1, "t1_dev");
        wr_byte(8'h00, 1'b1, "t1_wa");
        wr_byte(8'h11, 1'b1, "t1_d0");
        wr_byte(8'h22, 1'b1, "t1_d1");
        wr_byte(8'h33, 1'b1, "t1_d2");
        stop_c();
        rand_read_setup(8'h00, "t1r");
        rd_byte(8'h11, 1'b1, "t1_rd0");
        rd_byte(8'h22, 1'b1, "t1_rd1");
        rd_byte(8'h33, 1'b0, "t1_rd2");
        stop_c();

        // wrong device address
        start_c();
        wr_byte(8'hA2, 1'b0, "t2_dev_nack");
        wr_byte(8'h00, 1'b0, "t2_wa_nack");
        wr_byte(8'h55, 1'b0, "t2_d_nack");
        stop_c();
        rand_read_setup(8'h00, "t2r");
        rd_byte(8'h11, 1'b0, "t2_unchanged");
        stop_c();

        // pointer wrap
        start_c();
        wr_byte(8'hA0, 1'b1, "t4_dev");
        wr_byte(8'hFF, 1'b1, "t4_wa");
        wr_byte(8'hAA, 1'b1, "t4_d0");
        wr_byte(8'hBB, 1'b1, "t4_d1");
        stop_c();
        rand_read_setup(8'hFF, "t4r");
        rd_byte(8'hAA, 1'b1, "t4_rd_ff");
        rd_byte(8'hBB, 1'b0, "t4_rd_00");
        stop_c();

        // aborted write byte
        start_c();
        wr_byte(8'hA0, 1'b1, "t5_dev");
        wr_byte(8'h10, 1'b1, "t5_wa");
        wr_byte(8'h5A, 1'b1, "t5_d");
        stop_c();
        start_c();
        wr_byte(8'hA0, 1'b1, "t5_dev2");
        wr_byte(8'h10, 1'b1, "t5_wa2");
        for (int i = 0; i < 4; i++) bit_cycle(1'b0, r);
        stop_c();
        start_c();
        wr_byte(8'hA1, 1'b1, "t5_dev_rd");
        rd_byte(8'h5A, 1'b0, "t5_kept");
        stop_c();

        // reset during read byte (mem[0]=BB: bit6 is driven low)
        rand_read_setup(8'h00, "t6r");
        bit_cycle(1'b1, r);
        push_exp("t6_bit7", 8'h01);
        obs_val.push_back({7'd0, r});
        push_exp("t6_pre_low", 8'h00);
        obs_val.push_back({7'd0, sda_w});
        rst_n = 1'b0;
        #1;
        push_exp("t6_rst_release", 8'h01);
        obs_val.push_back({7'd0, sda_w});
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        #Q;
        stop_c();
        start_c();
        wr_byte(8'hA1, 1'b1, "t6_dev");
        rd_byte(8'hFF, 1'b0, "t6_ptr0");
        stop_c();
        rand_read_setup(8'h10, "t6m");
        rd_byte(8'hFF, 1'b0, "t6_mem_reset");
        stop_c();

        repeat (5) @(negedge clk);
        checks++;
        if (exp_val.size() == 0) passes++;
        else $display("FAIL leftover_expect: got %0d pending, required 0",
                      exp_val.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
